// File: rtl/sram_arbiter_if.sv
// Requester-side bundle of sram_arbiter: video read port, CPU and DMA read/write ports, shared rdata.
// Requests are levels held until the matching one-cycle ack; no other backpressure exists.
interface sram_arbiter_if;
  logic        vid_req;
  logic [20:0] vid_addr;
  logic        vid_ack;
  logic        cpu_req;
  logic        cpu_we;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic        dma_req;
  logic        dma_we;
  logic [20:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  rdata;

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  vid_ack, cpu_ack, dma_ack, rdata
  );

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output vid_ack, cpu_ack, dma_ack, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares an 8-bit async SRAM between video, CPU and DMA; access = ADDR + STROBE_CYCLES + DONE, ack in DONE.
// Requesters wait (req held) until acked; video > CPU > DMA, with DMA promoted over CPU once starved.
module sram_arbiter #(
  parameter int STROBE_CYCLES = 2,
  parameter int DMA_STARVE    = 4
) (
  input  logic          sysclk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  output logic [20:0]   sram_addr,
  output logic [7:0]    sram_data_out,
  output logic          sram_data_oe,
  input  logic [7:0]    sram_data_in,
  output logic          sram_we_n
);
  typedef enum logic [1:0] {IDLE, ADDR, STROBE, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_DMA} owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(DMA_STARVE);

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt, grant;
  logic [2:0]  cnt, cnt_nxt;
  logic [3:0]  starve, starve_nxt;
  logic        lat_we, lat_we_nxt;
  logic [20:0] addr_nxt;
  logic [7:0]  wdata_nxt, rdata_nxt;
  logic        oe_nxt, we_n_nxt;
  logic        vid_vld, cpu_vld, dma_vld;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      cnt           <= '0;
      starve        <= '0;
      lat_we        <= 1'b0;
      sram_addr     <= '0;
      sram_data_out <= '0;
      sram_data_oe  <= 1'b0;
      sram_we_n     <= 1'b1;
      bus.rdata     <= '0;
      bus.vid_ack   <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.dma_ack   <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      cnt           <= cnt_nxt;
      starve        <= starve_nxt;
      lat_we        <= lat_we_nxt;
      sram_addr     <= addr_nxt;
      sram_data_out <= wdata_nxt;
      sram_data_oe  <= oe_nxt;
      sram_we_n     <= we_n_nxt;
      bus.rdata     <= rdata_nxt;
      bus.vid_ack   <= (state_nxt == DONE) && (owner_nxt == OWN_VID);
      bus.cpu_ack   <= (state_nxt == DONE) && (owner_nxt == OWN_CPU);
      bus.dma_ack   <= (state_nxt == DONE) && (owner_nxt == OWN_DMA);
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cnt_nxt    = cnt;
    starve_nxt = starve;
    lat_we_nxt = lat_we;
    addr_nxt   = sram_addr;
    wdata_nxt  = sram_data_out;
    rdata_nxt  = bus.rdata;
    grant      = OWN_NONE;

    // The finishing owner's level req is not yet a new request in its own DONE cycle.
    vid_vld = bus.vid_req && !(state == DONE && owner == OWN_VID);
    cpu_vld = bus.cpu_req && !(state == DONE && owner == OWN_CPU);
    dma_vld = bus.dma_req && !(state == DONE && owner == OWN_DMA);

    if (state == IDLE || state == DONE) begin
      if (vid_vld)                             grant = OWN_VID;
      else if (dma_vld && starve == STARVE_MAX) grant = OWN_DMA;
      else if (cpu_vld)                        grant = OWN_CPU;
      else if (dma_vld)                        grant = OWN_DMA;

      if (grant == OWN_CPU && dma_vld)
        starve_nxt = (starve == STARVE_MAX) ? starve : starve + 4'd1;
      else if (grant != OWN_VID)
        starve_nxt = '0;
    end

    case (state)
      IDLE, DONE: begin
        owner_nxt = grant;
        case (grant)
          OWN_VID: begin
            state_nxt  = ADDR;
            addr_nxt   = bus.vid_addr;
            lat_we_nxt = 1'b0;
          end
          OWN_CPU: begin
            state_nxt  = ADDR;
            addr_nxt   = bus.cpu_addr;
            wdata_nxt  = bus.cpu_wdata;
            lat_we_nxt = bus.cpu_we;
          end
          OWN_DMA: begin
            state_nxt  = ADDR;
            addr_nxt   = bus.dma_addr;
            wdata_nxt  = bus.dma_wdata;
            lat_we_nxt = bus.dma_we;
          end
          default: begin
            state_nxt  = IDLE;
            lat_we_nxt = 1'b0;
          end
        endcase
      end
      ADDR: begin
        state_nxt = STROBE;
        cnt_nxt   = 3'(STROBE_CYCLES);
      end
      STROBE: begin
        if (cnt == 3'd1) begin
          state_nxt = DONE;
          if (!lat_we) rdata_nxt = sram_data_in;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: ;
    endcase

    // Driving data from ADDR through DONE gives write setup and hold around the we_n pulse.
    oe_nxt   = (state_nxt != IDLE) && lat_we_nxt;
    we_n_nxt = !((state_nxt == STROBE) && lat_we_nxt);
  end
endmodule
